// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite bitmap ROM between
// several pixel-fetch engines. Each cycle one requester is granted, its
// address is registered onto the ROM port, and a {valid, tag} pipeline
// matched to the ROM latency steers the returning data back to it.
module sprite_rom_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDRW   = 10,
  parameter int unsigned DATAW   = 3,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     line,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDRW-1:0]   req_addr,
  output logic [N_REQ-1:0]         gnt,
  output logic [ADDRW-1:0]         rom_addr,
  input  logic [DATAW-1:0]         rom_data,
  output logic [N_REQ-1:0]         rd_valid,
  output logic [DATAW-1:0]         rd_data,
  output logic [$clog2(N_REQ)-1:0] rd_tag
);

  localparam int unsigned PTRW = $clog2(N_REQ);
  localparam int unsigned LAST = ROM_LAT;

  logic [PTRW-1:0]  ptr_q,      ptr_d;
  logic [ADDRW-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0] vld_q,      vld_d;
  logic [PTRW-1:0]  tag_q [ROM_LAT+1];
  logic [PTRW-1:0]  tag_d [ROM_LAT+1];

  logic [N_REQ-1:0] gnt_c;
  logic [PTRW-1:0]  win_c;
  logic             any_gnt_c;

  // Round-robin search starting at ptr; first pending requester wins, none while in reset
  always_comb begin : p_arb
    int unsigned idx;
    gnt_c     = '0;
    win_c     = '0;
    any_gnt_c = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (rst_n && !any_gnt_c && req[PTRW'(idx)]) begin
        any_gnt_c           = 1'b1;
        win_c               = PTRW'(idx);
        gnt_c[PTRW'(idx)]   = 1'b1;
      end
    end
  end

  // Next pointer and ROM address; a line pulse restarts the order at 0
  always_comb begin : p_next
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) begin
        rom_addr_d = req_addr[i*ADDRW +: ADDRW];
      end
    end
    if (line) begin
      ptr_d = '0;
    end else if (any_gnt_c) begin
      ptr_d = (win_c == PTRW'(N_REQ - 1)) ? '0 : win_c + PTRW'(1);
    end
  end

  // Tag pipeline shifts every cycle; stage 0 captures this cycle's grant
  always_comb begin : p_pipe
    vld_d    = {vld_q[ROM_LAT-1:0], any_gnt_c};
    tag_d[0] = win_c;
    for (int unsigned s = 1; s <= ROM_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // State registers with synchronous active-low reset; reset discards in-flight reads
  always_ff @(posedge clk) begin : p_regs
    if (!rst_n) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      vld_q      <= '0;
      for (int unsigned s = 0; s <= ROM_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      vld_q      <= vld_d;
      for (int unsigned s = 0; s <= ROM_LAT; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  // Decode the last pipeline stage into a one-hot valid and an owner tag
  always_comb begin : p_out
    rd_valid = '0;
    rd_tag   = '0;
    if (vld_q[LAST]) begin
      rd_tag = tag_q[LAST];
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (tag_q[LAST] == PTRW'(i)) begin
          rd_valid[i] = 1'b1;
        end
      end
    end
  end

  assign gnt      = gnt_c;
  assign rom_addr = rom_addr_q;
  assign rd_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM latency 1 and 3), each
// with a behavioural ROM, a round-robin reference model and a scoreboard of
// expected {due cycle, tag, data} returns.
module tb_sprite_rom_arbiter;

  typedef struct packed {
    logic [31:0] due;
    logic [1:0]  tag;
    logic [2:0]  data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        line1, line3;
  logic [3:0]  req1, req3;
  logic [39:0] addr1, addr3;
  logic [3:0]  gnt1, gnt3;
  logic [9:0]  ra1, ra3;
  logic [2:0]  rom1, rom3;
  logic [2:0]  r3a, r3b;
  logic [3:0]  rdv1, rdv3;
  logic [2:0]  rdd1, rdd3;
  logic [1:0]  rdt1, rdt3;

  int         vectors;
  int         errors;
  int         cyc_n;
  exp_t       q1[$];
  exp_t       q3[$];
  int         mptr [2];
  int         mw   [2];
  logic [9:0] maddr[2];

  sprite_rom_arbiter #(.N_REQ(4), .ADDRW(10), .DATAW(3), .ROM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .line(line1), .req(req1), .req_addr(addr1),
    .gnt(gnt1), .rom_addr(ra1), .rom_data(rom1),
    .rd_valid(rdv1), .rd_data(rdd1), .rd_tag(rdt1)
  );

  sprite_rom_arbiter #(.N_REQ(4), .ADDRW(10), .DATAW(3), .ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .line(line3), .req(req3), .req_addr(addr3),
    .gnt(gnt3), .rom_addr(ra3), .rom_data(rom3),
    .rd_valid(rdv3), .rd_data(rdd3), .rd_tag(rdt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input logic [9:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6] ^ {2'b00, a[9]};
  endfunction

  // Behavioural ROMs: latency 1 and latency 3 from the registered address
  always @(posedge clk) begin
    rom1 <= rom_fn(ra1);
    r3a  <= rom_fn(ra3);
    r3b  <= r3a;
    rom3 <= r3b;
  end

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int o = 0; o < 4; o++) begin
      if (((r >> ((p + o) % 4)) & 4'b0001) != 4'b0000) return (p + o) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] rq, input logic [39:0] ad,
                            input logic ln, input logic [3:0] g, input logic [9:0] ra,
                            input logic [3:0] rv, input logic [1:0] rt, input logic [2:0] rd);
    exp_t q[$];
    exp_t e;
    int   w;
    int   lat;
    if (k == 0) begin
      q = q1; lat = 1;
    end else begin
      q = q3; lat = 3;
    end
    if (q.size() > 0 && q[0].due == 32'(cyc_n)) begin
      e = q.pop_front();
      chk($sformatf("rd_valid%0d", k), 32'(rv), 32'(1) << e.tag);
      chk($sformatf("rd_tag%0d", k),   32'(rt), 32'(e.tag));
      chk($sformatf("rd_data%0d", k),  32'(rd), 32'(e.data));
    end else begin
      chk($sformatf("rd_valid%0d_idle", k), 32'(rv), 32'(0));
      chk($sformatf("rd_tag%0d_idle", k),   32'(rt), 32'(0));
    end
    chk($sformatf("rom_addr%0d", k), 32'(ra), 32'(maddr[k]));
    w = (rst_n === 1'b1) ? rr_pick(rq, mptr[k]) : -1;
    chk($sformatf("gnt%0d", k), 32'(g), (w >= 0) ? (32'(1) << w) : 32'(0));
    mw[k] = w;
    if (rst_n !== 1'b1) begin
      mptr[k]  = 0;
      maddr[k] = '0;
      q.delete();
    end else begin
      if (w >= 0) begin
        e.due  = 32'(cyc_n + 1 + lat);
        e.tag  = 2'(w);
        e.data = rom_fn(ad[w*10 +: 10]);
        q.push_back(e);
        maddr[k] = ad[w*10 +: 10];
      end
      if (ln) mptr[k] = 0;
      else if (w >= 0) mptr[k] = (w + 1) % 4;
    end
    if (k == 0) q1 = q;
    else q3 = q;
  endtask

  task automatic cyc();
    #1;
    model_step(0, req1, addr1, line1, gnt1, ra1, rdv1, rdt1, rdd1);
    model_step(1, req3, addr3, line3, gnt3, ra3, rdv3, rdt3, rdd3);
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0; errors = 0; cyc_n = 0;
    mptr = '{0, 0}; mw = '{-1, -1}; maddr = '{10'd0, 10'd0};
    rst_n = 1'b0; line1 = 1'b0; line3 = 1'b0;
    req1 = '0; req3 = '0; addr1 = '0; addr3 = '0;
    @(negedge clk); @(negedge clk);
    cyc();                                 // reset state
    rst_n = 1'b1;

    // single requester, address 37
    req1 = 4'b0001; addr1[9:0] = 10'd37; cyc();
    req1 = 4'b0000; repeat (3) cyc();

    // round-robin with wrap from ptr=0
    line1 = 1'b1; cyc(); line1 = 1'b0;
    req1 = 4'b1111;
    for (int i = 0; i < 4; i++) addr1[i*10 +: 10] = 10'(100 + i);
    repeat (10) cyc();
    req1 = 4'b0000; repeat (3) cyc();

    // line override at ptr=2
    req1 = 4'b0010; cyc();
    req1 = 4'b1111; line1 = 1'b1; cyc(); line1 = 1'b0;
    repeat (2) cyc();
    req1 = 4'b0000; repeat (3) cyc();

    // reset with a read in flight
    req1 = 4'b0010; addr1[19:10] = 10'd55; cyc();
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; req1 = 4'b0000; repeat (4) cyc();
    req1 = 4'b1111; cyc();
    req1 = 4'b0000; repeat (3) cyc();

    // requester 3 alone, back-to-back over the whole address space
    req1 = 4'b1000;
    for (int a = 0; a < 1024; a++) begin
      addr1[39:30] = 10'(a);
      cyc();
    end
    req1 = 4'b0000; repeat (4) cyc();

    // latency-3 instance: alternating requesters 1 and 2, then both contending
    for (int n = 0; n < 16; n++) begin
      req3  = (n % 2 == 1) ? 4'b0100 : 4'b0010;
      addr3 = 40'({$urandom(), $urandom()});
      cyc();
    end
    req3 = 4'b0110; addr3 = 40'({$urandom(), $urandom()});
    repeat (10) cyc();
    req3 = 4'b0000; repeat (5) cyc();

    // random traffic honouring hold-until-granted, with sporadic line pulses
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req1[i] == 1'b0 || mw[0] == i) begin
          req1[i]           = 1'($urandom_range(0, 1));
          addr1[i*10 +: 10] = 10'($urandom());
        end
      end
      line1 = ($urandom_range(0, 7) == 0);
      cyc();
    end
    req1 = 4'b0000; line1 = 1'b0; repeat (5) cyc();

    chk("q1_drained", 32'(q1.size()), 32'(0));
    chk("q3_drained", 32'(q3.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
